// File: rtl/decrypter_pipe.sv
// decrypter_pipe
//   Two-stage pipelined frame decrypter with valid/ready handshakes on both
//   sides, plus saturating good/error frame counters.
//
//   Frame layout (in_frame): {mode[MODE_W], key[KEY_W], cipher[DATA_W]}.
//   Modes: 0 = XOR with replicated key, 1 = subtract replicated key,
//          2 = rotate right by (key mod DATA_W); codes >= NUM_MODES are
//          illegal and yield out_data=0 with out_err=1.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_frame/in_valid    input frame and its valid
//   in_ready             block can accept a frame this cycle
//   out_data/out_err     plaintext and illegal-mode flag
//   out_valid/out_ready  output valid and consumer ready
//   cnt_clr              synchronous clear of both counters (wins over count)
//   ok_cnt/err_cnt       saturating delivered-frame counters
module decrypter_pipe #(
  parameter int DATA_W    = 60,
  parameter int KEY_W     = 16,
  parameter int MODE_W    = 2,
  parameter int NUM_MODES = 3,
  parameter int CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [MODE_W+KEY_W+DATA_W-1:0]   in_frame,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_err,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             cnt_clr,
  output logic [CNT_W-1:0]                 ok_cnt,
  output logic [CNT_W-1:0]                 err_cnt
);

  localparam int ROT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int MOD_W = KEY_W + ROT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Frame field extraction
  logic [MODE_W-1:0] in_mode;
  logic [KEY_W-1:0]  in_key;
  logic [DATA_W-1:0] in_cipher;
  logic [DATA_W-1:0] in_rep;
  logic [MOD_W-1:0]  key_mod;
  logic [ROT_W-1:0]  in_rot;

  assign in_mode   = in_frame[MODE_W+KEY_W+DATA_W-1 -: MODE_W];
  assign in_key    = in_frame[KEY_W+DATA_W-1 -: KEY_W];
  assign in_cipher = in_frame[DATA_W-1:0];

  // Key repeated from the LSB upward, truncated to DATA_W bits.
  for (genvar i = 0; i < DATA_W; i++) begin : g_rep
    assign in_rep[i] = in_key[i % KEY_W];
  end

  // Widened so the modulus result always fits ROT_W bits, even for tiny keys.
  assign key_mod = MOD_W'(in_key) % MOD_W'(DATA_W);
  assign in_rot  = key_mod[ROT_W-1:0];

  // Stage advance: S2 refills when empty or draining; S1 refills when empty
  // or when S2 takes its contents. in_ready is combinational from out_ready.
  logic s1_valid;
  logic s2_load;
  logic s1_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
    end
  end

  logic [MODE_W-1:0] s1_mode;
  logic [DATA_W-1:0] s1_rep;
  logic [ROT_W-1:0]  s1_rot;
  logic [DATA_W-1:0] s1_cipher;

  // NOTE: the S1 payload is qualified by s1_valid, so it carries no reset;
  // only control state needs a defined value out of reset.
  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_mode   <= in_mode;
      s1_rep    <= in_rep;
      s1_rot    <= in_rot;
      s1_cipher <= in_cipher;
    end
  end

  // Stage 2 datapath
  logic [2*DATA_W-1:0] rot_dbl;
  logic [DATA_W-1:0]   s2_data;
  logic                s2_err;

  // Rotating a doubled copy keeps rot=0 well defined (no shift by DATA_W).
  assign rot_dbl = {s1_cipher, s1_cipher} >> s1_rot;

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    s2_data = '0;
    s2_err  = 1'b0;
    if (32'(s1_mode) >= 32'(NUM_MODES)) begin
      s2_err = 1'b1;
    end else begin
      case (32'(s1_mode))
        32'd0:   s2_data = s1_cipher ^ s1_rep;
        32'd1:   s2_data = s1_cipher - s1_rep;
        32'd2:   s2_data = rot_dbl[DATA_W-1:0];
        default: s2_err  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_data;
        out_err  <= s2_err;
      end
    end
  end

  // Saturating status counters; clear wins over a same-cycle delivery.
  logic out_hs;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (cnt_clr) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (out_hs) begin
      if (out_err) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
      end else begin
        if (ok_cnt != CNT_MAX) ok_cnt <= ok_cnt + CNT_W'(1);
      end
    end
  end

endmodule
